// File: rtl/vend_fsm_param_if.sv
// Coin/select/refund handshake and status bundle for vend_fsm_param.
// The master side (user panel) drives the requests; the controller is the slave.
interface vend_fsm_param_if #(
   parameter int CREDIT_W = 4,
   parameter int SEL_W    = 2
);
   logic                coin_valid;
   logic [CREDIT_W-1:0] coin_val;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel;
   logic                cancel;
   logic                dispense;
   logic [SEL_W-1:0]    product;
   logic [CREDIT_W-1:0] credit;
   logic                deny;
   logic                coin_reject;
   logic                change_pulse;
   logic                busy;

   modport master (
      output coin_valid, coin_val, sel_valid, sel, cancel,
      input  dispense, product, credit, deny, coin_reject, change_pulse, busy
   );

   modport slave (
      input  coin_valid, coin_val, sel_valid, sel, cancel,
      output dispense, product, credit, deny, coin_reject, change_pulse, busy
   );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit register, N priced products, unit change.
// Define VEND_CHANGE_EN to pay back the post-vend remainder through CHANGE.
module vend_fsm_param #(
   parameter int                         CREDIT_W = 4,
   parameter int                         N_PROD   = 4,
   parameter logic [N_PROD*CREDIT_W-1:0] PRICES   = {4'd7, 4'd5, 4'd3, 4'd2},
   parameter int                         SEL_W    = $clog2(N_PROD)
) (
   input logic            clk,
   input logic            rst,
   vend_fsm_param_if.slave bus
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   state_t              state;
   logic [CREDIT_W-1:0] credit_q;
   logic [SEL_W-1:0]    product_q;
   logic                dispense_q;
   logic                deny_q;
   logic                coin_reject_q;
   logic                change_pulse_q;
   logic                busy_q;

   logic [CREDIT_W-1:0] price;
   logic                sel_ok;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_nz;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path can infer a latch.
      price  = '0;
      sel_ok = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            price  = PRICES[i*CREDIT_W +: CREDIT_W];
            sel_ok = 1'b1;
         end
      end
   end

   // The extra top bit of the sum is the overflow flag.
   assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_val};
   assign coin_nz  = bus.coin_valid && (bus.coin_val != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         credit_q       <= '0;
         product_q      <= '0;
         dispense_q     <= 1'b0;
         deny_q         <= 1'b0;
         coin_reject_q  <= 1'b0;
         change_pulse_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
         dispense_q     <= 1'b0;
         deny_q         <= 1'b0;
         coin_reject_q  <= 1'b0;
         change_pulse_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cancel) begin
                  if (credit_q != '0) begin
                     state          <= CHANGE;
                     busy_q         <= 1'b1;
                     change_pulse_q <= 1'b1;
                     credit_q       <= credit_q - 1'b1;
                  end
                  coin_reject_q <= coin_nz;
               end else if (bus.sel_valid) begin
                  if (sel_ok && (credit_q >= price)) begin
                     state      <= VEND;
                     busy_q     <= 1'b1;
                     dispense_q <= 1'b1;
                     credit_q   <= credit_q - price;
                     product_q  <= bus.sel;
                  end else begin
                     deny_q <= 1'b1;
                  end
                  coin_reject_q <= coin_nz;
               end else if (coin_nz) begin
                  if (!coin_sum[CREDIT_W]) credit_q <= coin_sum[CREDIT_W-1:0];
                  else                     coin_reject_q <= 1'b1;
               end
            end
            VEND: begin
               coin_reject_q <= coin_nz;
`ifdef VEND_CHANGE_EN
               if (credit_q != '0) begin
                  state          <= CHANGE;
                  change_pulse_q <= 1'b1;
                  credit_q       <= credit_q - 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
`else
               state  <= IDLE;
               busy_q <= 1'b0;
`endif
            end
            CHANGE: begin
               coin_reject_q <= coin_nz;
               // The last pulse is the one that leaves credit at zero; leave a cycle later.
               if (credit_q != '0) begin
                  change_pulse_q <= 1'b1;
                  credit_q       <= credit_q - 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dispense     = dispense_q;
   assign bus.product      = product_q;
   assign bus.credit       = credit_q;
   assign bus.deny         = deny_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.change_pulse = change_pulse_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param (defaults: CREDIT_W=4, prices p0=2 p1=3 p2=5 p3=7).
// Each step queues the expected output vector, then checks it one cycle later.
module tb_vend_fsm_param;

   logic clk;
   logic rst;

   vend_fsm_param_if #(.CREDIT_W(4), .SEL_W(2)) bus ();

   vend_fsm_param dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [10:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Expected vector layout: dispense, product[1:0], credit[3:0], deny, coin_reject, change_pulse, busy
   function automatic logic [10:0] e(input logic disp, input logic [1:0] prod, input logic [3:0] cred,
                                     input logic dny, input logic crej, input logic chg, input logic bsy);
      return {disp, prod, cred, dny, crej, chg, bsy};
   endfunction

   task automatic step(input string tag, input logic cv, input logic [3:0] cval,
                       input logic sv, input logic [1:0] s, input logic cn, input logic [10:0] expv);
      exp_t        x;
      logic [10:0] obs;
      bus.coin_valid = cv;
      bus.coin_val   = cval;
      bus.sel_valid  = sv;
      bus.sel        = s;
      bus.cancel     = cn;
      sb.push_back('{tag: tag, v: expv});
      @(posedge clk);
      #1;
      bus.coin_valid = 1'b0;
      bus.coin_val   = '0;
      bus.sel_valid  = 1'b0;
      bus.sel        = '0;
      bus.cancel     = 1'b0;
      x   = sb.pop_front();
      obs = {bus.dispense, bus.product, bus.credit, bus.deny,
             bus.coin_reject, bus.change_pulse, bus.busy};
      n_checks++;
      assert (obs === x.v) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
      end
   endtask

   task automatic idle(input string tag, input logic [10:0] expv);
      step(tag, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, expv);
   endtask

   task automatic coin(input string tag, input logic [3:0] val, input logic [10:0] expv);
      step(tag, 1'b1, val, 1'b0, 2'd0, 1'b0, expv);
   endtask

   task automatic select(input string tag, input logic [1:0] s, input logic [10:0] expv);
      step(tag, 1'b0, 4'd0, 1'b1, s, 1'b0, expv);
   endtask

   task automatic cancel(input string tag, input logic [10:0] expv);
      step(tag, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, expv);
   endtask

   initial begin
      bus.coin_valid = 1'b0;
      bus.coin_val   = '0;
      bus.sel_valid  = 1'b0;
      bus.sel        = '0;
      bus.cancel     = 1'b0;
      rst = 1'b1;
      idle("reset_a", e(0, 0, 0, 0, 0, 0, 0));
      idle("reset_b", e(0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;

      // Coins 2,2,1 then product 2 (price 5): exact payment, no change
      coin("coin2_a", 4'd2, e(0, 0, 2, 0, 0, 0, 0));
      coin("coin2_b", 4'd2, e(0, 0, 4, 0, 0, 0, 0));
      coin("coin1",   4'd1, e(0, 0, 5, 0, 0, 0, 0));
      select("sel2_vend", 2'd2, e(1, 2, 0, 0, 0, 0, 1));
      idle("sel2_done", e(0, 2, 0, 0, 0, 0, 0));

      // Credit 7, product 0 (price 2): remainder 5
      coin("coin4", 4'd4, e(0, 2, 4, 0, 0, 0, 0));
      coin("coin3", 4'd3, e(0, 2, 7, 0, 0, 0, 0));
      select("sel0_vend", 2'd0, e(1, 0, 5, 0, 0, 0, 1));
`ifdef VEND_CHANGE_EN
      idle("chg_4", e(0, 0, 4, 0, 0, 1, 1));
`else
      idle("keep_rem", e(0, 0, 5, 0, 0, 0, 0));
      cancel("cancel5", e(0, 0, 4, 0, 0, 1, 1));
`endif
      for (int k = 3; k >= 0; k--) idle($sformatf("chg_%0d", k), e(0, 0, 4'(k), 0, 0, 1, 1));
      idle("chg_end", e(0, 0, 0, 0, 0, 0, 0));

      // Credit 3, product 3 (price 7): deny; a coin beside a select is rejected
      coin("coin3b", 4'd3, e(0, 0, 3, 0, 0, 0, 0));
      select("deny_sel3", 2'd3, e(0, 0, 3, 1, 0, 0, 0));
      step("deny_coin", 1'b1, 4'd1, 1'b1, 2'd3, 1'b0, e(0, 0, 3, 1, 1, 0, 0));
      idle("deny_pulse_end", e(0, 0, 3, 0, 0, 0, 0));

      // Overflow boundary: 14 + 2 rejected, 14 + 1 reaches max, zero coin ignored
      coin("coin11", 4'd11, e(0, 0, 14, 0, 0, 0, 0));
      coin("ovf_coin2", 4'd2, e(0, 0, 14, 0, 1, 0, 0));
      coin("max_coin1", 4'd1, e(0, 0, 15, 0, 0, 0, 0));
      coin("zero_coin", 4'd0, e(0, 0, 15, 0, 0, 0, 0));
      cancel("cancel15", e(0, 0, 14, 0, 0, 1, 1));
      for (int k = 13; k >= 0; k--) idle($sformatf("drain_%0d", k), e(0, 0, 4'(k), 0, 0, 1, 1));
      idle("drain_end", e(0, 0, 0, 0, 0, 0, 0));

      // Credit 4, cancel; coin, select and cancel during change all ignored or rejected
      coin("coin4b", 4'd4, e(0, 0, 4, 0, 0, 0, 0));
      cancel("cancel4", e(0, 0, 3, 0, 0, 1, 1));
      step("busy_coin", 1'b1, 4'd1, 1'b1, 2'd0, 1'b1, e(0, 0, 2, 0, 1, 1, 1));
      idle("cancel4_p3", e(0, 0, 1, 0, 0, 1, 1));
      idle("cancel4_p4", e(0, 0, 0, 0, 0, 1, 1));
      idle("cancel4_end", e(0, 0, 0, 0, 0, 0, 0));

      // Vend product 1 so product is nonzero, then reset during the 2nd change pulse
      coin("coin3c", 4'd3, e(0, 0, 3, 0, 0, 0, 0));
      select("sel1_vend", 2'd1, e(1, 1, 0, 0, 0, 0, 1));
      idle("sel1_done", e(0, 1, 0, 0, 0, 0, 0));
      coin("coin4c", 4'd4, e(0, 1, 4, 0, 0, 0, 0));
      cancel("rst_cancel", e(0, 1, 3, 0, 0, 1, 1));
      idle("rst_p2", e(0, 1, 2, 0, 0, 1, 1));
      rst = 1'b1;
      idle("rst_mid_change", e(0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      idle("post_rst", e(0, 0, 0, 0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
